// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int DEF_REG_W        = 5;
  localparam int DEF_MEM_TIMEOUT  = 255;
  localparam int DEF_DRAIN_CYCLES = 3;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_HALTED   = 3'd3,
    ST_FAULT    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register
// a load in EX is about to write. Purely combinational so the forwarding
// unit can share it.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic             ex_writeOrder,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use = ex_is_load && ex_writeOrder && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: per-stage enables/flushes for PC, IF/ID,
// ID/EX and EX/MEM, with memory-wait timeout, drain-then-halt and a
// saturating stall-cycle counter.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_RUN      | normal issue; resolves branch, load-use, halt request
// ST_MEM_WAIT | pipeline frozen on an outstanding MEM access; wait_q counts
// ST_DRAIN    | PC held, bubbles fed into IF/ID until the pipe is empty
// ST_HALTED   | everything frozen until resume
// ST_FAULT    | memory timeout; frozen until reset
module pipe_seq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = DEF_REG_W,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic             ex_writeOrder,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  seq_state_e         state_q, state_d;
  seq_state_e         ret_q, ret_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               halt_pend_q, halt_pend_d;
  logic               halted_q, fault_q;
  logic [CNT_W-1:0]   stall_q;

  logic load_use;
  logic mem_stall;
  logic stall_inc;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_is_load   (ex_is_load),
    .ex_writeOrder(ex_writeOrder),
    .ex_rd        (ex_rd),
    .load_use     (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  // Next-state, counter updates and Mealy strobes.
  // drain_q counts drain cycles already issued. The RUN cycle that accepts
  // the halt already drives drain strobes, so it is drain cycle 0 and the
  // whole sequence is exactly DRAIN_CYCLES cycles long.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    wait_d      = wait_q;
    drain_d     = drain_q;
    halt_pend_d = halt_pend_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    if (halt_req && (state_q != ST_HALTED) && (state_q != ST_FAULT)) begin
      halt_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          ret_d   = ST_RUN;
          wait_d  = WAIT_ONE;
        end else if (branch_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          idex_flush = 1'b1;
        end else if (halt_pend_q || halt_req) begin
          ifid_en     = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          ifid_flush  = 1'b1;
          halt_pend_d = 1'b0;
          if (DRAIN_CYCLES == 1) begin
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_ONE;
          end
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ready) begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          state_d  = ret_q;
          wait_d   = '0;
          if (ret_q == ST_DRAIN) begin
            halt_pend_d = 1'b0;
          end
        end else if (wait_q == WAIT_MAX) begin
          exmem_flush = 1'b1;
          state_d     = ST_FAULT;
          wait_d      = '0;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      ST_DRAIN: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          ret_d   = ST_DRAIN;
          wait_d  = WAIT_ONE;
        end else begin
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = branch_taken;
          if (drain_q == DRAIN_LAST) begin
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q + DRAIN_ONE;
          end
        end
      end

      ST_HALTED: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Strobes must already be quiet while reset is held, not just after
    // the flops have cleared.
    if (!reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  assign stall_inc = !pc_en &&
                     ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT) || (state_q == ST_DRAIN));

  // State, counters, flags and the saturating stall counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      wait_q      <= '0;
      drain_q     <= '0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      wait_q      <= wait_d;
      drain_q     <= drain_d;
      halt_pend_q <= halt_pend_d;
      halted_q    <= (state_d == ST_HALTED);
      fault_q     <= (state_d == ST_FAULT);
      if (stall_inc && !(&stall_q)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign halted       = halted_q;
  assign fault        = fault_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: the driver runs a behavioural model
// each cycle and queues the expected outputs; a monitor on the falling edge
// pops and compares them against the DUT.
module tb_pipe_seq_ctrl;

  localparam int REG_W        = 5;
  localparam int MEM_TIMEOUT  = 5;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 8;
  localparam int STALL_MAX    = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic             ex_is_load = 1'b0, ex_writeOrder = 1'b0;
  logic             branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic             halt_req = 1'b0, resume = 1'b0;
  logic             pc_en, ifid_en, idex_en, exmem_en;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic             halted, fault;
  logic [CNT_W-1:0] stall_cycles;

  pipe_seq_ctrl #(
    .REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_writeOrder(ex_writeOrder), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .halted(halted), .fault(fault), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pc_en, ifid_en, idex_en, exmem_en;
    int ifid_flush, idex_flush, exmem_flush;
    int halted, fault, stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: plain flags and integer counts taken from the rules.
  bit m_halted, m_fault, m_waiting, m_draining, m_ret_drain, m_pend;
  int m_wait_len, m_drains_done, m_stall;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_fault = 0; m_waiting = 0; m_draining = 0; m_ret_drain = 0;
    m_pend = 0; m_wait_len = 0; m_drains_done = 0; m_stall = 0;
  endtask

  task automatic all_en(inout exp_t e);
    e.pc_en = 1; e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1;
  endtask

  task automatic model_step();
    exp_t e;
    bit   active, hz, mstall, clr_pend;
    e = '{default: 0};
    if (!reset) begin
      model_reset();
      sb_q.push_back(e);
      return;
    end
    e.halted = int'(m_halted);
    e.fault  = int'(m_fault);
    e.stall  = m_stall;
    active   = !m_halted && !m_fault;
    hz = ex_is_load && ex_writeOrder && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    mstall   = mem_req && !mem_ready;
    clr_pend = 0;
    if (m_fault) begin
      // frozen
    end else if (m_halted) begin
      if (resume) m_halted = 0;
    end else if (m_waiting) begin
      if (mem_ready) begin
        all_en(e);
        m_waiting = 0;
        if (m_ret_drain) begin m_draining = 1; clr_pend = 1; end
      end else if (m_wait_len == MEM_TIMEOUT) begin
        e.exmem_flush = 1;
        m_waiting = 0;
        m_fault = 1;
      end else begin
        m_wait_len++;
      end
    end else if (mstall) begin
      m_waiting = 1; m_wait_len = 1; m_ret_drain = m_draining; m_draining = 0;
    end else if (!m_draining && branch_taken) begin
      all_en(e); e.ifid_flush = 1; e.idex_flush = 1;
    end else if (!m_draining && hz) begin
      e.idex_en = 1; e.exmem_en = 1; e.idex_flush = 1;
    end else if (m_draining || m_pend || halt_req) begin
      if (!m_draining) begin m_draining = 1; m_drains_done = 0; clr_pend = 1; end
      e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1; e.ifid_flush = 1;
      e.idex_flush = int'(branch_taken);
      m_drains_done++;
      if (m_drains_done == DRAIN_CYCLES) begin m_draining = 0; m_halted = 1; end
    end else begin
      all_en(e);
    end
    if (clr_pend) m_pend = 0;
    else if (active && halt_req) m_pend = 1;
    if (active && e.pc_en == 0 && m_stall < STALL_MAX) m_stall++;
    sb_q.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_is_load = 0; ex_writeOrder = 0; branch_taken = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0; resume = 0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1; ex_writeOrder = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
  endtask

  // Monitor: compare queued expectations on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_en",        int'(pc_en),        e.pc_en);
        chk("ifid_en",      int'(ifid_en),      e.ifid_en);
        chk("idex_en",      int'(idex_en),      e.idex_en);
        chk("exmem_en",     int'(exmem_en),     e.exmem_en);
        chk("ifid_flush",   int'(ifid_flush),   e.ifid_flush);
        chk("idex_flush",   int'(idex_flush),   e.idex_flush);
        chk("exmem_flush",  int'(exmem_flush),  e.exmem_flush);
        chk("halted",       int'(halted),       e.halted);
        chk("fault",        int'(fault),        e.fault);
        chk("stall_cycles", int'(stall_cycles), e.stall);
      end
    end
  end

  initial begin
    model_reset();
    set_idle();
    reset = 0;
    @(posedge clock);
    #1;
    step(); step();
    reset = 1;
    step(); step();

    // Load-use: one bubble, one stall counted.
    set_load_use();
    step();
    chk("lu_stall_count", int'(stall_cycles), 1);
    set_idle();
    step();
    set_load_use(); ex_rd = '0; id_rs1 = '0;
    step();
    set_load_use(); id_uses_rs1 = 0;
    step();
    set_idle();
    step();
    chk("no_hazard_stall_count", int'(stall_cycles), 1);

    // Four-cycle memory wait, then completion.
    mem_req = 1;
    repeat (4) step();
    mem_ready = 1;
    step();
    set_idle();
    step();
    chk("memwait_stall_count", int'(stall_cycles), 5);

    // Branch overrides a simultaneous load-use hazard.
    set_load_use(); branch_taken = 1;
    step();
    set_idle();
    step();
    chk("branch_no_stall", int'(stall_cycles), 5);

    // Halt pulse: three drain cycles, then halted; resume returns to RUN.
    halt_req = 1;
    step();
    halt_req = 0;
    step(); step();
    chk("halted_after_drain", int'(halted), 1);
    step(); step();
    resume = 1;
    step();
    resume = 0;
    step();
    chk("resumed", int'(halted), 0);

    // Memory timeout: FAULT latches until reset.
    mem_req = 1;
    repeat (MEM_TIMEOUT + 1) step();
    chk("fault_set", int'(fault), 1);
    mem_ready = 1;
    step(); step();
    set_idle();
    reset = 0;
    step(); step();
    reset = 1;
    step();
    chk("fault_cleared", int'(fault), 0);

    // Reset in the middle of a drain leaves no halt pending.
    halt_req = 1;
    step();
    halt_req = 0;
    step();
    reset = 0;
    step(); step();
    reset = 1;
    step();
    chk("reset_drain_halted", int'(halted), 0);
    chk("reset_drain_stall", int'(stall_cycles), 0);
    repeat (4) step();

    // Saturation of the stall counter.
    set_load_use();
    repeat (STALL_MAX + 45) step();
    chk("stall_saturated", int'(stall_cycles), STALL_MAX);
    set_idle();
    reset = 0;
    step();
    reset = 1;
    step();

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      reset         = ($urandom_range(0, 149) != 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      id_uses_rs1   = ($urandom_range(0, 1) == 1);
      id_uses_rs2   = ($urandom_range(0, 1) == 1);
      ex_is_load    = ($urandom_range(0, 2) == 0);
      ex_writeOrder = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      mem_req       = ($urandom_range(0, 4) == 0);
      mem_ready     = ($urandom_range(0, 2) == 0);
      halt_req      = ($urandom_range(0, 29) == 0);
      resume        = ($urandom_range(0, 3) == 0);
      step();
    end

    set_idle();
    reset = 1;
    step();
    @(negedge clock);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_seq_ctrl.md
# pipe_seq_ctrl

Pipeline sequencing controller for the five-stage processor. Generates the per-stage enable and flush strobes for the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken-branch flushes, multi-cycle memory waits with a timeout, and a drain-then-halt sequence. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_W, 5, register-address width
- MEM_TIMEOUT, 255, maximum consecutive wait cycles before FAULT (≥1)
- DRAIN_CYCLES, 3, bubble cycles inserted before HALTED (≥1)
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- ex_is_load  in  1  instruction in EX is a load
- ex_writeOrder  in  1  instruction in EX writes the register file
- ex_rd  in  REG_W  destination register in EX
- branch_taken  in  1  branch resolved taken in EX this cycle
- mem_req  in  1  MEM stage has an outstanding access
- mem_ready  in  1  access completes this cycle
- halt_req  in  1  request halt (level or pulse)
- resume  in  1  leave HALTED
- pc_en, ifid_en, idex_en, exmem_en  out  1  register load enables
- ifid_flush, idex_flush, exmem_flush  out  1  synchronous clear to bubble
- halted  out  1  in HALTED
- fault  out  1  in FAULT
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 in RUN/DRAIN/MEM_WAIT

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED, FAULT. Reset state is RUN.
- Strobes are a Mealy function of the state and the current inputs. halted, fault, stall_cycles and halt_pend are registered.
- halt_pend flag:
  - Set by halt_req in any state except HALTED and FAULT.
  - Cleared on entry to DRAIN.
- Load-use hazard: ex_is_load & ex_writeOrder & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, evaluated in priority order:
  1. mem_req & !mem_ready: all enables 0, no flush. Go to MEM_WAIT with return=RUN and wait_cnt=1.
  2. branch_taken: all enables 1, ifid_flush=idex_flush=1. Overrides load-use.
  3. Load-use hazard: pc_en=ifid_en=0, idex_flush=1, exmem_en=1.
  4. halt_pend or halt_req: go to DRAIN with drain_cnt=0. Strobes this cycle follow the DRAIN rule.
  5. Otherwise all enables 1, no flush.
- MEM_WAIT:
  - Enables 0, flushes 0, wait_cnt increments each cycle.
  - mem_ready: enables 1, return to the saved state.
  - wait_cnt==MEM_TIMEOUT without mem_ready: go to FAULT.
- DRAIN:
  - pc_en=0 and ifid_flush=1; the other enables are 1.
  - drain_cnt increments; at drain_cnt==DRAIN_CYCLES-1, go to HALTED.
  - mem_req & !mem_ready: enter MEM_WAIT with return=DRAIN; drain_cnt holds.
  - branch_taken in DRAIN: idex_flush=1 as well.
- HALTED: all enables 0 and halted=1. resume moves to RUN. halt_req is ignored.
- FAULT: all enables 0, fault=1. Only reset exits.
- exmem_flush is asserted only when entering FAULT, to clear the in-flight MEM control bits (sw*, writeOrder).
- stall_cycles saturates at all-ones; it does not wrap.

## Timing
- While reset=0, and immediately on assertion: all enables 0, all flushes 0, halted=0, fault=0, stall_cycles=0, counters cleared, halt_pend=0.
- Reset mid-operation aborts any state and returns to RUN with no residual flush.
- Strobes are valid in the same cycle as the causing inputs and take effect at the next rising edge. There is no added latency.
- Load-use costs exactly 1 bubble cycle per hazard.
- A branch costs 2 flushed slots.
- A memory wait of N cycles stalls N cycles. The completing cycle is not a stall.
- DRAIN lasts exactly DRAIN_CYCLES cycles plus any memory waits. halted rises on the edge after the last drain cycle.
- FAULT entry happens on the edge where wait_cnt reaches MEM_TIMEOUT. fault is visible the next cycle.
- Simultaneous halt_req and mem wait: the mem wait wins and halt_pend is latched.
- Simultaneous halt_req and branch: the branch flush applies and DRAIN starts the next cycle.

## Structure
- Package pipe_ctrl_pkg contains:
  - the state enum (RUN, MEM_WAIT, DRAIN, HALTED, FAULT);
  - default REG_W, MEM_TIMEOUT, DRAIN_CYCLES and CNT_W constants.
- Sub-module hazard_detect is the purely combinational load-use comparator. It is reused by the forwarding unit.
- Top level contains the FSM, wait_cnt, drain_cnt, halt_pend, the return-state register and the stall counter.

## Test plan
- ex_is_load=1, ex_writeOrder=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle:
  - pc_en=ifid_en=0 and idex_flush=1 for exactly 1 cycle;
  - stall_cycles 0→1.
- Same as above but ex_rd=0, then id_uses_rs1=0: no stall, all enables 1.
- mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1:
  - enables 0 for 4 cycles, then 1;
  - stall_cycles +4;
  - with MEM_TIMEOUT=3 instead: fault=1, exmem_flush pulse, enables stuck at 0 until reset.
- branch_taken with a load-use hazard in the same cycle: ifid_flush=idex_flush=1, pc_en=1, no stall counted.
- halt_req pulse in RUN: 3 cycles of pc_en=0 and ifid_flush=1, then halted=1; resume gives RUN with pc_en=1 the next cycle.
- Reset deasserted mid-DRAIN (after a 2-cycle low pulse): all outputs 0 during reset, then RUN with stall_cycles=0 and no halt pending.
